// File: rtl/pipeline_pkg.sv
// Shared definitions for the elastic pipeline stage register.
//   stage_state_t : occupancy state of a stage (EMPTY / ONE / TWO held entries)
//   ctrl_bundle_t : control bundle carried alongside the datapath payload
//   CTRL_WIDTH    : width of ctrl_bundle_t, used as the stage's default
//   CTRL_NOP      : all-zero control value presented for bubbles
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic [3:0] alu_func;
    logic [1:0] wb_sel;
    logic [2:0] imm_sel;
    logic [1:0] rsvd;
  } ctrl_bundle_t;

  localparam int unsigned  CTRL_WIDTH = $bits(ctrl_bundle_t);
  localparam ctrl_bundle_t CTRL_NOP   = '0;

endpackage

// File: rtl/saturating_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   reset : asynchronous active-low reset, clears count
//   inc   : count up by one (holds at all-ones)
//   clr   : synchronous clear, wins over inc
//   count : current value
module saturating_counter #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   clr,
  output logic [COUNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stage_register.sv
// Elastic pipeline stage with a 2-entry skid buffer (main = head, skid = overflow).
//   clk, reset          : clock, asynchronous active-low reset
//   flush               : synchronous kill of all held entries
//   in_valid/in_ready   : upstream handshake; in_ready comes from the state register
//   in_data/in_ctrl     : upstream payload and control bundle
//   out_valid/out_ready : downstream handshake
//   out_data/out_ctrl   : head entry (zeroed on bubbles when ZERO_ON_BUBBLE=1)
//   occupancy           : number of held entries (0..2)
//   clear_stats         : synchronous clear of stall_count
//   stall_count         : saturating count of out_valid & !out_ready cycles
module pipeline_stage_register #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned CTRL_WIDTH     = pipeline_pkg::CTRL_WIDTH,
  parameter bit          ZERO_ON_BUBBLE = 1'b1,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic [1:0]             occupancy,
  input  logic                   clear_stats,
  output logic [COUNT_WIDTH-1:0] stall_count
);

  import pipeline_pkg::*;

  localparam logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = CTRL_WIDTH'(CTRL_NOP);

  stage_state_t          state_q, state_d;
  logic [WIDTH-1:0]      main_data_q, skid_data_q;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, skid_ctrl_q;
  logic                  in_fire, out_fire;
  logic                  load_main_in, load_main_skid, load_skid;

  // Handshake outputs decode the state register only: no out_ready -> in_ready path.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Offered entry is dropped; storage keeps its old contents.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (load_main_in) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    out_data = main_data_q;
    out_ctrl = main_ctrl_q;
    if (ZERO_ON_BUBBLE && !out_valid) begin
      out_data = '0;
      out_ctrl = BUBBLE_CTRL;
    end
  end

  saturating_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_stall_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid & ~out_ready),
    .clr  (clear_stats),
    .count(stall_count)
  );

endmodule

// File: tb/tb_pipeline_stage_register.sv
module tb_pipeline_stage_register;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, in_valid, out_ready, clear_stats;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [15:0] a_out_ctrl;
  logic [1:0]  a_occ;
  logic [3:0]  a_stall;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [15:0] b_out_ctrl;
  logic [1:0]  b_occ;
  logic [15:0] b_stall;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  // a: bubbles zeroed, 4-bit stall counter; b: stale head visible, 16-bit counter
  pipeline_stage_register #(
    .WIDTH(32), .CTRL_WIDTH(16), .ZERO_ON_BUBBLE(1'b1), .COUNT_WIDTH(4)
  ) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .occupancy(a_occ),
    .clear_stats(clear_stats), .stall_count(a_stall)
  );

  pipeline_stage_register #(
    .WIDTH(32), .CTRL_WIDTH(16), .ZERO_ON_BUBBLE(1'b0), .COUNT_WIDTH(16)
  ) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .occupancy(b_occ),
    .clear_stats(clear_stats), .stall_count(b_stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ctrl_of(input logic [31:0] d);
    return d[15:0] ^ 16'hA5C3;
  endfunction

  // Reference model: a FIFO of at most two entries plus the last head seen.
  typedef struct packed {
    logic [31:0] d;
    logic [15:0] c;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_stale = '0;
  int unsigned m_stall4 = 0;
  int unsigned m_stall16 = 0;
  bit          m_ov, m_ir;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_stale   = '0;
      m_stall4  = 0;
      m_stall16 = 0;
    end else begin
      m_ov = (mq.size() > 0);
      m_ir = (mq.size() < 2);
      if (clear_stats) begin
        m_stall4  = 0;
        m_stall16 = 0;
      end else if (m_ov && !out_ready) begin
        if (m_stall4 < 15) m_stall4++;
        if (m_stall16 < 65535) m_stall16++;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (m_ov && out_ready) void'(mq.pop_front());
        if (in_valid && m_ir) mq.push_back({in_data, in_ctrl});
      end
      if (mq.size() > 0) m_stale = mq[0];
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("a_out_valid", a_out_valid, mq.size() > 0);
      chk("a_in_ready",  a_in_ready,  mq.size() < 2);
      chk("a_occupancy", a_occ,       mq.size());
      chk("a_out_data",  a_out_data,  (mq.size() > 0) ? mq[0].d : 32'd0);
      chk("a_out_ctrl",  a_out_ctrl,  (mq.size() > 0) ? mq[0].c : 16'd0);
      chk("a_stall",     a_stall,     m_stall4);
      chk("b_out_valid", b_out_valid, mq.size() > 0);
      chk("b_in_ready",  b_in_ready,  mq.size() < 2);
      chk("b_occupancy", b_occ,       mq.size());
      chk("b_out_data",  b_out_data,  (mq.size() > 0) ? mq[0].d : m_stale.d);
      chk("b_out_ctrl",  b_out_ctrl,  (mq.size() > 0) ? mq[0].c : m_stale.c);
      chk("b_stall",     b_stall,     m_stall16);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = ctrl_of(d);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0; clear_stats = 1'b0;
    offer(1'b0, 32'd0);
    tick(); tick();
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_in_ready",  a_in_ready,  1'b1);
    chk("rst_occ",       a_occ,       2'd0);
    chk("rst_b_data",    b_out_data,  32'd0);
    chk("rst_stall",     a_stall,     4'd0);
    reset = 1'b1;

    // Stream: 1-cycle latency, full throughput
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      offer(1'b1, 32'h100 + i);
      tick();
      chk("stream_data",  a_out_data, 32'h100 + i);
      chk("stream_ready", a_in_ready, 1'b1);
    end
    offer(1'b0, 32'd0);
    tick();
    chk("drain_valid",  a_out_valid, 1'b0);
    chk("bubble_a",     a_out_data,  32'd0);
    chk("bubble_b",     b_out_data,  32'h107);
    chk("bubble_b_ctl", b_out_ctrl,  ctrl_of(32'h107));
    chk("stream_stall", a_stall,     4'd0);

    // Skid fill and drain
    out_ready = 1'b0;
    offer(1'b1, 32'hA); tick();
    offer(1'b1, 32'hB); tick();
    chk("skid_occ",   a_occ,      2'd2);
    chk("skid_ready", a_in_ready, 1'b0);
    chk("skid_head",  a_out_data, 32'hA);
    offer(1'b1, 32'hC); tick();
    chk("skid_noacc", a_occ,      2'd2);
    offer(1'b0, 32'd0); out_ready = 1'b1; tick();
    chk("skid_2nd",   a_out_data, 32'hB);
    chk("skid_stall", a_stall,    4'd2);
    tick();
    chk("skid_empty", a_out_valid, 1'b0);
    chk("skid_b_stale", b_out_data, 32'hB);

    // Flush while full, with a concurrent offer that must be discarded
    out_ready = 1'b0;
    offer(1'b1, 32'h1); tick();
    offer(1'b1, 32'h2); tick();
    flush = 1'b1; offer(1'b1, 32'hC); tick();
    chk("flush_occ",   a_occ,       2'd0);
    chk("flush_valid", a_out_valid, 1'b0);
    chk("flush_ctrl",  a_out_ctrl,  16'd0);
    chk("flush_stale", b_out_data,  32'h1);
    flush = 1'b0; offer(1'b0, 32'd0);
    tick(); tick();

    // Saturation and clear
    clear_stats = 1'b1; offer(1'b1, 32'h77); tick();
    clear_stats = 1'b0; offer(1'b0, 32'd0);
    for (int unsigned i = 0; i < 20; i++) tick();
    chk("sat_a", a_stall, 4'd15);
    chk("sat_b", b_stall, 16'd20);
    clear_stats = 1'b1; tick();
    chk("clr_zero", a_stall, 4'd0);
    clear_stats = 1'b0; tick();
    chk("clr_one", a_stall, 4'd1);

    // Asynchronous reset between edges while full
    offer(1'b1, 32'h78); tick();
    offer(1'b0, 32'd0);
    chk("pre_rst_occ", a_occ, 2'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", a_out_valid, 1'b0);
    chk("arst_ready", a_in_ready,  1'b1);
    chk("arst_occ",   a_occ,       2'd0);
    chk("arst_data",  a_out_data,  32'd0);
    chk("arst_bdata", b_out_data,  32'd0);
    chk("arst_stall", a_stall,     4'd0);
    offer(1'b1, 32'h99);
    tick(); tick();
    chk("rst_nosample", a_occ, 2'd0);
    reset = 1'b1; out_ready = 1'b1; offer(1'b1, 32'h55);
    tick();
    chk("post_rst_valid", a_out_valid, 1'b1);
    chk("post_rst_data",  a_out_data,  32'h55);
    offer(1'b0, 32'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
